// File: rtl/adc_sample_scheduler.sv
// Snapshots 8 ADC channels every PERIOD cycles and streams the changed, enabled channels as ch/data items.
// Latency: tick -> first out_valid in 2 cycles (SNAP, then registered item); back-to-back items, no bubble.
// Backpressure: out_valid/out_ready; item held stable while stalled; ticks arriving while busy are dropped and counted.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   enable            runs the tick counter; low clears it and stops new snapshots
//   ch_mask           per-channel enable, sampled only in the SNAP cycle
//   adc_data          live 8x12-bit channel values
//   out_valid/ready   item handshake; out_ch/out_data/out_last describe the item
//   busy              high whenever a snapshot or scan is in progress
//   overrun_count     saturating count of ticks dropped while busy
module adc_sample_scheduler #(
    parameter int PERIOD   = 50000,
    parameter int DEADBAND = 2,
    parameter int CW       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [7:0]       ch_mask,
    input  logic [7:0][11:0] adc_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_ch,
    output logic [11:0]      out_data,
    output logic             out_last,
    output logic             busy,
    output logic [7:0]       overrun_count
);

    typedef enum logic [1:0] {IDLE, SNAP, SCAN} state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD - 1);
    localparam logic [11:0]   DB       = 12'(DEADBAND);

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic             tick;
    logic [7:0][11:0] snap;
    logic [7:0][11:0] last;
    logic [7:0]       first;
    logic [7:0]       pend;
    logic [7:0]       pend_new;
    logic [7:0]       pend_after;
    logic [2:0]       ch_from_snap;
    logic [2:0]       ch_from_scan;
    logic             hs;

    // Index of the lowest set bit (0 when none set).
    function automatic logic [2:0] lowest(input logic [7:0] p);
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (p[i]) lowest = 3'(i);
        end
    endfunction

    function automatic logic single_bit(input logic [7:0] p);
        return (p != 8'd0) && ((p & (p - 8'd1)) == 8'd0);
    endfunction

    // Unsigned distance, never wraps: |000 - FFF| = FFF.
    function automatic logic [11:0] absdiff(input logic [11:0] a, input logic [11:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign tick = enable && (count == LAST_CNT);
    assign busy = (state != IDLE);
    assign hs   = out_valid && out_ready;

    // Channels that qualify for emission if snapshotted this cycle.
    always_comb begin
        pend_new = '0;
        for (int n = 0; n < 8; n++) begin
            pend_new[n] = ch_mask[n] & (first[n] | (absdiff(adc_data[n], last[n]) > DB));
        end
    end

    assign pend_after   = pend & ~(8'd1 << out_ch);
    assign ch_from_snap = lowest(pend_new);
    assign ch_from_scan = lowest(pend_after);

    always_ff @(posedge clk) begin
        if (reset || !enable || tick) count <= '0;
        else                          count <= count + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)                                                    overrun_count <= 8'd0;
        else if (tick && state != IDLE && overrun_count != 8'hFF)     overrun_count <= overrun_count + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = SNAP;
            SNAP:    state_nxt = (pend_new != 8'd0) ? SCAN : IDLE;
            SCAN:    if (hs && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Item registers are loaded from the live ADC bus during SNAP (same values
    // that land in snap) and from snap on each accepted handshake thereafter.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap      <= '0;
            last      <= '0;
            first     <= 8'hFF;
            pend      <= 8'd0;
            out_valid <= 1'b0;
            out_ch    <= 3'd0;
            out_data  <= 12'd0;
            out_last  <= 1'b0;
        end else if (state == SNAP) begin
            snap      <= adc_data;
            pend      <= pend_new;
            out_valid <= (pend_new != 8'd0);
            out_ch    <= ch_from_snap;
            out_data  <= adc_data[ch_from_snap];
            out_last  <= single_bit(pend_new);
        end else if (state == SCAN && hs) begin
            last[out_ch]  <= out_data;
            first[out_ch] <= 1'b0;
            pend          <= pend_after;
            out_valid     <= (pend_after != 8'd0);
            out_ch        <= ch_from_scan;
            out_data      <= snap[ch_from_scan];
            out_last      <= single_bit(pend_after);
        end
    end

endmodule
